// File: rtl/spi_pkg.sv
// Definitions shared by the SPI master and target cores: FSM state encoding
// and the CPOL/CPHA mode constants both ends of the bus must agree on.
package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } spi_state_e;

  // SCLK idle level
  localparam bit CPOL_LOW   = 1'b0;
  localparam bit CPOL_HIGH  = 1'b1;

  // Which SCLK edge samples data
  localparam bit CPHA_LEAD  = 1'b0;
  localparam bit CPHA_TRAIL = 1'b1;

  // Conventional SPI mode number 0..3 for a given CPOL/CPHA pair
  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by a history
// flop so rising/falling edges of the synchronised level can be detected.
module spi_sync_edge #(
  parameter int   SYNC_STG = 2,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] sync_q;
  logic [SYNC_STG-1:0] sync_d;
  logic                hist_q;
  logic                hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], din};
    hist_d = sync_q[SYNC_STG-1];
  end

  // Reset to the pin's idle level so no spurious edge appears after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STG{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign dout = sync_q[SYNC_STG-1];
  assign rise = dout & ~hist_q;
  assign fall = ~dout & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI target endpoint: oversamples the host's SCLK/CS_N/MOSI in the clk domain,
// deserialises MOSI words to rx_* and serialises held tx_* words onto MISO.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int REG_WIDTH = 16,
  parameter bit CPOL      = CPOL_HIGH,
  parameter bit CPHA      = CPHA_TRAIL,
  parameter int SYNC_STG  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SPI_CS_N,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_MOSI,
  output logic                 SPI_MISO,
  output logic                 SPI_MISO_OE,
  input  logic [REG_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [REG_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 underrun,
  output logic                 frame_err
);

  localparam int                CNT_W    = $clog2(REG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SPI_CS_N),
    .dout (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(CPOL)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SPI_SCLK),
    .dout (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Same depth as SCLK, so the synced MOSI is aligned with the detected edge
  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SPI_MOSI),
    .dout (mosi_sync),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  spi_state_e           state_q, state_d;
  logic [REG_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [REG_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REG_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 underrun_q, underrun_d;
  logic                 frame_err_q, frame_err_d;
  logic [REG_WIDTH-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 reload_pend_q, reload_pend_d;
  logic                 load_req;
  logic                 hold_wr;
  logic [REG_WIDTH-1:0] rx_word;

  assign rx_word = {rx_shift_q[REG_WIDTH-2:0], mosi_sync};
  assign hold_wr = tx_valid && !hold_full_q;

  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    cnt_d         = cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    frame_err_d   = 1'b0;
    reload_pend_d = reload_pend_q;
    load_req      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) state_d = S_LOAD;
      end

      S_LOAD: begin
        load_req      = 1'b1;
        cnt_d         = '0;
        rx_shift_d    = '0;
        reload_pend_d = 1'b0;
        state_d       = cs_rise ? S_IDLE : S_SHIFT;
      end

      S_SHIFT: begin
        if (cs_rise) begin
          state_d       = S_IDLE;
          frame_err_d   = (cnt_q != '0);
          cnt_d         = '0;
          reload_pend_d = 1'b0;
        end else if (sample_edge) begin
          rx_shift_d = rx_word;
          if (cnt_q == CNT_LAST) begin
            rx_data_d     = rx_word;
            rx_valid_d    = 1'b1;
            cnt_d         = '0;
            reload_pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (shift_edge) begin
          // First shift edge after a completed word presents the next word's MSB
          if (reload_pend_q) begin
            load_req      = 1'b1;
            reload_pend_d = 1'b0;
          end else if (!((CPHA == 1'b1) && (cnt_q == '0))) begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load_req) begin
      tx_shift_d = hold_full_q ? hold_q : '0;
      underrun_d = !hold_full_q;
    end
  end

  // A write in the same clk as a reload lands after the reload took the old content
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load_req) hold_full_d = 1'b0;
    if (hold_wr) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      cnt_q         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      reload_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      cnt_q         <= cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
      frame_err_q   <= frame_err_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      reload_pend_q <= reload_pend_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign SPI_MISO    = tx_shift_q[REG_WIDTH-1];
  assign SPI_MISO_OE = busy && !cs_sync;
  assign tx_ready    = !hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign underrun    = underrun_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: one mode-0 and one mode-3 target driven by a host
// model; received words are scoreboarded, MISO words and pulse counts per frame.
`timescale 1ns/1ps
module tb_spi_slave_core;

  localparam int W    = 16;
  localparam int HALF = 4;   // clk cycles per SCLK half period -> f_SCLK = f_clk/8

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   cs_n;
  logic [1:0]   sclk;
  logic         mosi;
  logic [W-1:0] tx_data;
  logic         tx_valid  [2];
  logic         miso      [2];
  logic         miso_oe   [2];
  logic         tx_ready  [2];
  logic [W-1:0] rx_data   [2];
  logic         rx_valid  [2];
  logic         busy      [2];
  logic         underrun  [2];
  logic         frame_err [2];

  spi_slave_core #(.REG_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STG(2)) u_mode0 (
    .clk(clk), .rst_n(rst_n), .SPI_CS_N(cs_n[0]), .SPI_SCLK(sclk[0]), .SPI_MOSI(mosi),
    .SPI_MISO(miso[0]), .SPI_MISO_OE(miso_oe[0]), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]),
    .underrun(underrun[0]), .frame_err(frame_err[0])
  );

  spi_slave_core #(.REG_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STG(2)) u_mode3 (
    .clk(clk), .rst_n(rst_n), .SPI_CS_N(cs_n[1]), .SPI_SCLK(sclk[1]), .SPI_MOSI(mosi),
    .SPI_MISO(miso[1]), .SPI_MISO_OE(miso_oe[1]), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]),
    .underrun(underrun[1]), .frame_err(frame_err[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of received words, tagged with the instance index
  logic [W:0] rx_exp_q[$];
  int         ur_cnt[2];
  int         fe_cnt[2];

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rx_valid[m] === 1'b1) begin
        if (rx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: inst %0d got %h expected no word", m, rx_data[m]);
        end else begin
          logic [W:0] exp;
          exp = rx_exp_q.pop_front();
          check("rx_word", {15'd0, m[0], rx_data[m]}, {15'd0, exp});
        end
      end
      if (underrun[m] === 1'b1) ur_cnt[m]++;
      if (frame_err[m] === 1'b1) fe_cnt[m]++;
    end
  end

  // tx feeder: offers queued words to the selected instance whenever it is ready
  logic [W-1:0] feed_q[$];
  int           feed_m = 0;

  initial begin
    tx_valid[0] = 1'b0;
    tx_valid[1] = 1'b0;
    tx_data     = '0;
    forever begin
      @(negedge clk);
      tx_valid[0] = 1'b0;
      tx_valid[1] = 1'b0;
      if (rst_n === 1'b1 && feed_q.size() > 0 && tx_ready[feed_m] === 1'b1) begin
        tx_data          = feed_q.pop_front();
        tx_valid[feed_m] = 1'b1;
      end
    end
  end

  logic [W-1:0] f_mosi[4];
  logic [W-1:0] f_tx[4];

  // Words loaded into the tx shifter during a frame: one per word start; a
  // sample-on-leading target also reloads after every completed word.
  function automatic int calc_loads(input int m, input int nw, input int p);
    if (m == 1) return nw + ((p > 0) ? 1 : 0);
    return 1 + nw;
  endfunction

  task automatic sclk_bit(input int m, input logic b, output logic rd);
    if (m == 1) sclk[1] = 1'b0;
    mosi = b;
    repeat (HALF) @(negedge clk);
    rd = miso[m];
    sclk[m] = 1'b1;
    repeat (HALF) @(negedge clk);
    if (m == 0) sclk[0] = 1'b0;
  endtask

  task automatic preload(input int m, input logic [W-1:0] w);
    feed_m = m;
    feed_q.push_back(w);
    for (int i = 0; i < 40 && (feed_q.size() > 0 || tx_ready[m] === 1'b1); i++) @(negedge clk);
    check("preload_full", {31'd0, tx_ready[m]}, 32'd0);
  endtask

  task automatic run_frame(input int m, input int nw, input int p, input int ntx);
    int           ur0, fe0, loads;
    logic [W-1:0] rd_word;
    logic         rd;
    ur0   = ur_cnt[m];
    fe0   = fe_cnt[m];
    loads = calc_loads(m, nw, p);
    if (ntx > 0) preload(m, f_tx[0]);
    for (int k = 1; k < ntx; k++) feed_q.push_back(f_tx[k]);
    cs_n[m] = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    check("busy_in_frame", {31'd0, busy[m]}, 32'd1);
    check("oe_in_frame", {31'd0, miso_oe[m]}, 32'd1);
    if (m == 0) check("miso_pre_edge", {31'd0, miso[0]}, {31'd0, (ntx > 0) ? f_tx[0][W-1] : 1'b0});
    for (int k = 0; k < nw; k++) begin
      rx_exp_q.push_back({m[0], f_mosi[k]});
      rd_word = '0;
      for (int b = W - 1; b >= 0; b--) begin
        sclk_bit(m, f_mosi[k][b], rd);
        rd_word = {rd_word[W-2:0], rd};
      end
      check("miso_word", {16'd0, rd_word}, {16'd0, (k < ntx) ? f_tx[k] : 16'h0000});
    end
    for (int b = 0; b < p; b++) sclk_bit(m, 1'($urandom), rd);
    repeat (HALF) @(negedge clk);
    cs_n[m] = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_after", {31'd0, busy[m]}, 32'd0);
    check("oe_after", {31'd0, miso_oe[m]}, 32'd0);
    check("tx_ready_after", {31'd0, tx_ready[m]}, 32'd1);
    check("frame_err_cnt", fe_cnt[m] - fe0, (p > 0) ? 32'd1 : 32'd0);
    check("underrun_cnt", ur_cnt[m] - ur0, loads - ntx);
    check("rx_all_seen", rx_exp_q.size(), 32'd0);
    check("tx_all_taken", feed_q.size(), 32'd0);
    $display("frame inst=%0d words=%0d partial=%0d tx=%0d", m, nw, p, ntx);
  endtask

  task automatic check_reset_outputs(input int m);
    check("rst_miso", {31'd0, miso[m]}, 32'd0);
    check("rst_oe", {31'd0, miso_oe[m]}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
    check("rst_rx_data", {16'd0, rx_data[m]}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid[m]}, 32'd0);
    check("rst_busy", {31'd0, busy[m]}, 32'd0);
    check("rst_underrun", {31'd0, underrun[m]}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err[m]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rd;
    rst_n = 1'b0;
    cs_n  = 2'b11;
    sclk  = 2'b10;
    mosi  = 1'b0;
    ur_cnt[0] = 0; ur_cnt[1] = 0;
    fe_cnt[0] = 0; fe_cnt[1] = 0;
    repeat (4) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single word, both modes
    f_tx[0] = 16'hA55A; f_mosi[0] = 16'h1234;
    run_frame(1, 1, 0, 1);
    run_frame(0, 1, 0, 1);

    // Two back-to-back words under one CS
    f_mosi[0] = 16'h0001; f_mosi[1] = 16'hFFFE;
    f_tx[0]   = 16'h1111; f_tx[1]   = 16'h2222;
    run_frame(1, 2, 0, 2);
    run_frame(0, 2, 0, 2);

    // Nothing to send: zeros on MISO with underrun
    f_mosi[0] = 16'hBEEF;
    run_frame(1, 1, 0, 0);

    // CS released after 9 bits, then a clean frame
    f_tx[0] = 16'h0F0F;
    run_frame(1, 0, 9, 1);
    f_mosi[0] = 16'h1234; f_tx[0] = 16'hA55A;
    run_frame(1, 1, 0, 1);

    // Reset asserted mid-word
    preload(1, 16'h5A5A);
    cs_n[1] = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    for (int b = 0; b < 5; b++) sclk_bit(1, 1'b1, rd);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1);
    @(negedge clk);
    cs_n[1] = 1'b1;
    sclk[1] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs(1);
    f_mosi[0] = 16'hC3C3; f_tx[0] = 16'h7E81;
    run_frame(1, 1, 0, 1);

    // Randomised frames
    for (int i = 0; i < 16; i++) begin
      int m, nw, p, ntx;
      m  = int'($urandom_range(0, 1));
      nw = int'($urandom_range(0, 3));
      p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0;
      if (nw == 0 && p == 0) nw = 1;
      ntx = int'($urandom_range(0, calc_loads(m, nw, p)));
      for (int k = 0; k < 4; k++) begin
        f_mosi[k] = W'($urandom);
        f_tx[k]   = W'($urandom);
      end
      run_frame(m, nw, p, ntx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
